// File: rtl/conv_serializer_pkg.sv
// Shared convolution datapath types plus the serializer's state encoding.
package conv_serializer_pkg;

  localparam int DATA_W = 16;
  localparam int LEN    = 3;

  typedef logic [DATA_W-1:0] data_t;
  typedef data_t [LEN-1:0]   data_vector;

  typedef enum logic {
    SER_IDLE = 1'b0,
    SER_SEND = 1'b1
  } ser_state_t;

  localparam int SER_IDX_W = (LEN > 1) ? $clog2(LEN) : 1;

endpackage

// File: rtl/conv_serializer_if.sv
// Vector-in / element-out handshake bundle for conv_serializer.
interface conv_serializer_if #(
  parameter int LEN = conv_serializer_pkg::LEN
);
  import conv_serializer_pkg::*;

  data_t [LEN-1:0] in_vec;
  logic            in_valid;
  logic            in_ready;
  data_t           out_data;
  logic            out_valid;
  logic            out_last;
  logic            out_ready;

  modport master (
    output in_vec, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_vec, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

endinterface

// File: rtl/conv_serializer.sv
// Unpacks one LEN-element window per handshake into element-wide transfers, index 0 first.
// Define CONV_SER_PIPE_EN to accept the next window on the last element's transfer (no IDLE bubble).
module conv_serializer #(
  parameter int LEN   = conv_serializer_pkg::LEN,
  parameter int IDX_W = (LEN > 1) ? $clog2(LEN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  conv_serializer_if.slave bus
);
  import conv_serializer_pkg::*;

  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LEN - 1);

  ser_state_t       state_r;
  ser_state_t       state_nxt_s;
  logic [IDX_W-1:0] idx_r;
  logic [IDX_W-1:0] idx_nxt_s;
  data_t [LEN-1:0]  buf_r;
  data_t            out_data_s;
  logic             load_s;
  logic             last_s;
  logic             in_ready_s;
  logic             in_xfer_s;
  logic             out_xfer_s;

  assign last_s = (idx_r == IDX_LAST);

`ifdef CONV_SER_PIPE_EN
  // in_ready follows out_ready combinationally on the last element.
  assign in_ready_s = !rst && ((state_r == SER_IDLE) ||
                               ((state_r == SER_SEND) && last_s && bus.out_ready));
`else
  assign in_ready_s = !rst && (state_r == SER_IDLE);
`endif

  assign in_xfer_s  = bus.in_valid && in_ready_s;
  assign out_xfer_s = (state_r == SER_SEND) && bus.out_ready;

  // State, index and window buffer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= SER_IDLE;
      idx_r   <= IDX_ZERO;
      buf_r   <= {(LEN * DATA_W){1'b0}};
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      if (load_s) begin
        buf_r <= bus.in_vec;
      end
    end
  end

  // Next-state and index update
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    load_s      = 1'b0;
    case (state_r)
      SER_IDLE: begin
        if (in_xfer_s) begin
          load_s      = 1'b1;
          idx_nxt_s   = IDX_ZERO;
          state_nxt_s = SER_SEND;
        end else begin
          state_nxt_s = SER_IDLE;
        end
      end
      SER_SEND: begin
        if (out_xfer_s && last_s) begin
          idx_nxt_s = IDX_ZERO;
          if (in_xfer_s) begin
            load_s      = 1'b1;
            state_nxt_s = SER_SEND;
          end else begin
            state_nxt_s = SER_IDLE;
          end
        end else if (out_xfer_s) begin
          idx_nxt_s = idx_r + IDX_W'(1);
        end else begin
          idx_nxt_s = idx_r;
        end
      end
      default: begin
        state_nxt_s = SER_IDLE;
        idx_nxt_s   = IDX_ZERO;
      end
    endcase
  end

  // AND-OR element select keeps the mux free of out-of-range indexing
  always_comb begin
    out_data_s = {DATA_W{1'b0}};
    for (int i = 0; i < LEN; i++) begin
      out_data_s = out_data_s | ({DATA_W{idx_r == IDX_W'(i)}} & buf_r[i]);
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = (state_r == SER_SEND);
  assign bus.out_data  = out_data_s;
  assign bus.out_last  = (state_r == SER_SEND) && last_s;

endmodule

// File: tb/tb_conv_serializer.sv
// Self-checking bench: LEN=3 and LEN=1 serializers against a scoreboard plus hand-written corner sequences.
module tb_conv_serializer;
  import conv_serializer_pkg::*;

  typedef struct packed {
    data_t d;
    logic  l;
  } exp_t;

  typedef struct {
    data_t      vin [3];
    data_t      ex  [3];
    logic [2:0] exl;
  } vec_rec_t;

`ifdef CONV_SER_PIPE_EN
  localparam int B2B_GAP = 1;
`else
  localparam int B2B_GAP = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t q3 [$];
  exp_t q1 [$];
  int   cyc_q [$];
  exp_t e3, e1;
  vec_rec_t tbl [4];

  conv_serializer_if #(.LEN(3)) b3 ();
  conv_serializer_if #(.LEN(1)) b1 ();

  conv_serializer #(.LEN(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));
  conv_serializer #(.LEN(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic data_vector mk3(input data_t a, input data_t b, input data_t c);
    data_vector v;
    v[0] = a;
    v[1] = b;
    v[2] = c;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push3(input data_vector v);
    exp_t x;
    for (int i = 0; i < 3; i++) begin
      x.d = v[i];
      x.l = (i == 2);
      q3.push_back(x);
    end
  endtask

  // Holds in_valid until the DUT takes the vector; leaves in_valid asserted.
  task automatic offer3(input data_vector v, input bit do_push);
    bit ok;
    ok = 1'b0;
    b3.in_vec   = v;
    b3.in_valid = 1'b1;
    for (int k = 0; k < 40 && !ok; k++) begin
      if (b3.in_ready) begin
        if (do_push) push3(v);
        ok = 1'b1;
      end
      step();
    end
    if (!ok) chk("offer_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      if (q3.size() == 0 && q1.size() == 0 && !b3.out_valid && !b1.out_valid) done = 1'b1;
      else step();
    end
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  // Scoreboard: outputs sampled mid-cycle, transfer completes on the next rising edge
  always @(negedge clk) begin
    if (!rst && b3.out_valid && b3.out_ready) begin
      cyc_q.push_back(cyc);
      if (q3.size() == 0) begin
        chk("l3_unexpected_out", {16'd0, b3.out_data}, 32'hFFFF_FFFF);
      end else begin
        e3 = q3.pop_front();
        chk("l3_data", b3.out_data, e3.d);
        chk("l3_last", b3.out_last, e3.l);
      end
    end
    if (!rst && b1.out_valid && b1.out_ready) begin
      if (q1.size() == 0) begin
        chk("l1_unexpected_out", {16'd0, b1.out_data}, 32'hFFFF_FFFF);
      end else begin
        e1 = q1.pop_front();
        chk("l1_data", b1.out_data, e1.d);
        chk("l1_last", b1.out_last, e1.l);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    exp_t x1;
    tbl[0].vin = '{16'd5, 16'd6, 16'd7};         tbl[0].ex = '{16'd5, 16'd6, 16'd7};         tbl[0].exl = 3'b100;
    tbl[1].vin = '{16'hFFFF, 16'd0, 16'd1};      tbl[1].ex = '{16'hFFFF, 16'd0, 16'd1};      tbl[1].exl = 3'b100;
    tbl[2].vin = '{16'h1234, 16'hABCD, 16'h0F0F}; tbl[2].ex = '{16'h1234, 16'hABCD, 16'h0F0F}; tbl[2].exl = 3'b100;
    tbl[3].vin = '{16'd0, 16'd0, 16'd0};         tbl[3].ex = '{16'd0, 16'd0, 16'd0};         tbl[3].exl = 3'b100;

    b3.in_vec = mk3(16'd0, 16'd0, 16'd0); b3.in_valid = 1'b0; b3.out_ready = 1'b0;
    b1.in_vec[0] = 16'd0; b1.in_valid = 1'b0; b1.out_ready = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", b3.in_ready, 32'd0);
    chk("rst_out_valid", b3.out_valid, 32'd0);
    chk("rst_out_last", b3.out_last, 32'd0);
    chk("rst_out_data", b3.out_data, 32'd0);
    chk("rst_l1_in_ready", b1.in_ready, 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", b3.in_ready, 32'd1);
    chk("post_rst_out_valid", b3.out_valid, 32'd0);

    // basic: three consecutive elements, last flagged only on the third
    b3.out_ready = 1'b1;
    b1.out_ready = 1'b1;
    cyc_q.delete();
    offer3(mk3(16'd10, 16'd20, 16'd30), 1'b1);
    b3.in_valid = 1'b0;
    chk("basic_e0_data", b3.out_data, 32'd10);
    chk("basic_e0_last", b3.out_last, 32'd0);
    step();
    chk("basic_e1_data", b3.out_data, 32'd20);
    chk("basic_e1_last", b3.out_last, 32'd0);
    step();
    chk("basic_e2_data", b3.out_data, 32'd30);
    chk("basic_e2_last", b3.out_last, 32'd1);
    step();
    chk("basic_ready_again", b3.in_ready, 32'd1);
    chk("basic_idle_valid", b3.out_valid, 32'd0);
    chk("basic_out_count", cyc_q.size(), 32'd3);
    if (cyc_q.size() == 3) chk("basic_consecutive", cyc_q[2] - cyc_q[0], 32'd2);

    // table-driven vectors
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 3; j++) begin
        x1.d = tbl[i].ex[j];
        x1.l = tbl[i].exl[j];
        q3.push_back(x1);
      end
      offer3(mk3(tbl[i].vin[0], tbl[i].vin[1], tbl[i].vin[2]), 1'b0);
      b3.in_valid = 1'b0;
      drain();
    end

    // backpressure on element 1 while a new vector is offered and must be ignored
    offer3(mk3(16'd10, 16'd20, 16'd30), 1'b1);
    b3.in_vec = mk3(16'd7, 16'd8, 16'd9);
    chk("bp_e0_data", b3.out_data, 32'd10);
    step();
    b3.out_ready = 1'b0;
    chk("bp_e1_data", b3.out_data, 32'd20);
    step();
    chk("bp_hold1_data", b3.out_data, 32'd20);
    chk("bp_hold1_valid", b3.out_valid, 32'd1);
    chk("bp_hold1_last", b3.out_last, 32'd0);
    step();
    chk("bp_hold2_data", b3.out_data, 32'd20);
    chk("bp_hold2_valid", b3.out_valid, 32'd1);
    b3.out_ready = 1'b1;
    step();
    b3.in_valid = 1'b0;
    chk("bp_e2_data", b3.out_data, 32'd30);
    chk("bp_e2_last", b3.out_last, 32'd1);
    drain();

    // back-to-back with in_valid held high
    cyc_q.delete();
    offer3(mk3(16'd1, 16'd2, 16'd3), 1'b1);
    offer3(mk3(16'd4, 16'd5, 16'd6), 1'b1);
    b3.in_valid = 1'b0;
    drain();
    chk("b2b_count", cyc_q.size(), 32'd6);
    if (cyc_q.size() == 6) begin
      chk("b2b_first_run", cyc_q[2] - cyc_q[0], 32'd2);
      chk("b2b_gap", cyc_q[3] - cyc_q[2], B2B_GAP);
      chk("b2b_second_run", cyc_q[5] - cyc_q[3], 32'd2);
    end

    // reset in the middle of a vector
    offer3(mk3(16'd10, 16'd20, 16'd30), 1'b1);
    b3.in_valid = 1'b0;
    step();
    chk("rm_pre_data", b3.out_data, 32'd20);
    rst = 1'b1;
    #1;
    chk("rm_out_valid", b3.out_valid, 32'd0);
    chk("rm_in_ready", b3.in_ready, 32'd0);
    chk("rm_out_last", b3.out_last, 32'd0);
    q3.delete();
    step();
    step();
    rst = 1'b0;
    step();
    chk("rm_release_ready", b3.in_ready, 32'd1);
    chk("rm_release_valid", b3.out_valid, 32'd0);
    offer3(mk3(16'd4, 16'd5, 16'd6), 1'b1);
    b3.in_valid = 1'b0;
    drain();

    // LEN=1 instance: single element, always last
    b1.in_vec[0] = 16'd42;
    b1.in_valid  = 1'b1;
    chk("l1_in_ready", b1.in_ready, 32'd1);
    x1.d = 16'd42;
    x1.l = 1'b1;
    q1.push_back(x1);
    step();
    b1.in_valid = 1'b0;
    chk("l1_out_valid", b1.out_valid, 32'd1);
    chk("l1_out_data", b1.out_data, 32'd42);
    chk("l1_out_last", b1.out_last, 32'd1);
    step();
    chk("l1_back_idle_valid", b1.out_valid, 32'd0);
    chk("l1_back_idle_ready", b1.in_ready, 32'd1);

    drain();
    chk("final_q3_empty", q3.size(), 32'd0);
    chk("final_q1_empty", q1.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_serializer.md
Name: conv_serializer

Overview:
- Parallel-to-serial unpacker for the convolution datapath. It is the opposite direction of the sliding-window shifter.
- Accepts one full window (Conv::data_vector, Conv::LEN elements) per handshake.
- Emits the window one Conv::data_t element per transfer, index 0 first, and flags the final element.
- Used to stream windows or result vectors back onto element-wide links and into the testbench scoreboard.

Parameters:
- LEN, default Conv::LEN: number of elements per vector. Must be >= 1.
- IDX_W, default (LEN>1 ? $clog2(LEN) : 1): width of the element index counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- in_vec  input  Conv::data_vector  window to serialize.
- in_valid  input  1  in_vec is valid.
- in_ready  output  1  block can latch a vector this cycle.
- out_data  output  Conv::data_t  current element.
- out_valid  output  1  out_data is valid.
- out_last  output  1  out_data is element LEN-1.
- out_ready  input  1  downstream accepts out_data.

Behaviour:
- Reset and clocking:
  - One clock (clk); reset rst is asynchronous, active-high.
  - Reset values (applied immediately, asynchronously): state=IDLE, idx=0, vector buffer all 0.
  - Outputs during reset: in_ready=0, out_valid=0, out_last=0, out_data=0.
- Output decode (combinational from registers only; no input-to-output combinational path except as noted under CONV_SER_PIPE_EN):
  - in_ready = (state==IDLE) && !rst.
  - out_valid = (state==SEND).
  - out_data = buf[idx].
  - out_last = (state==SEND) && (idx==LEN-1).
- Transfers:
  - Input transfer: in_valid && in_ready at a rising edge.
  - Output transfer: out_valid && out_ready at a rising edge.
- States:
  - IDLE: on input transfer, buf<=in_vec, idx<=0, go to SEND. Otherwise hold.
  - SEND, output transfer with idx<LEN-1: idx<=idx+1.
  - SEND, output transfer with idx==LEN-1: idx<=0, go to IDLE.
  - SEND, no transfer (stall): hold everything; out_data and out_last must stay stable.
- Latency and throughput:
  - Element 0 is valid in the cycle after the input transfer.
  - Minimum LEN+1 cycles per vector (one IDLE bubble) when the feature is disabled.
- LEN==1: every element has out_last=1; the block returns to IDLE after a single output transfer.
- in_vec changing while in SEND is ignored; buf is only written on an input transfer.
- in_valid dropping before acceptance is legal; no state effect.
- Reset mid-SEND: the partial vector is discarded and never resumed; after reset release, in_ready=1 the next cycle.
- Illegal state encodings go to IDLE.

Optional Feature:
- Macro: CONV_SER_PIPE_EN.
- Defined (zero-bubble pipelining):
  - in_ready = !rst && ((state==IDLE) || (state==SEND && idx==LEN-1 && out_ready)).
  - A simultaneous last output transfer and input transfer loads buf<=in_vec, sets idx<=0 and keeps state SEND.
  - Sustained throughput: one vector per LEN cycles.
  - in_ready then depends combinationally on out_ready; this is documented and allowed.
- Undefined: behaviour exactly as in Behaviour, with one mandatory IDLE cycle between vectors.

Decomposition:
- Conv package additions:
  - typedef enum logic {SER_IDLE, SER_SEND} ser_state_t;
  - localparam SER_IDX_W.
  - Reuse of existing data_t, data_vector and LEN.
- Single module; no sub-module is natural. The index counter and FSM are inline.

Test Plan:
- Basic, LEN=3 bench build, out_ready=1: in_vec={10,20,30} -> out_data 10,20,30 on 3 consecutive cycles; out_last only on 30; in_ready high again the following cycle.
- Backpressure: same vector with out_ready low for 2 cycles while 20 is presented -> out_data stays 20 and out_valid stays 1 until accepted; no duplicated or skipped element.
- Back-to-back, in_valid held high with {1,2,3} then {4,5,6}:
  - Without the macro: 1,2,3, one bubble, 4,5,6.
  - With CONV_SER_PIPE_EN: 1..6 with no bubble.
- Input ignored while busy: change in_vec to {7,8,9} during SEND of {10,20,30} -> output remains 10,20,30.
- Reset mid-SEND: assert rst after element 20 -> out_valid=0 immediately, in_ready=0 during reset; after release, a new vector {4,5,6} emits 4,5,6 with no residue.
- LEN=1 build: in_vec={42} -> single output 42 with out_last=1, then IDLE.
